// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM with shared prescaler/period counter and double-buffered period/duty
module pwm_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 8,
  parameter int PRESC_WIDTH = 4
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                cs,
  input  logic                we,
  input  logic [3:0]          addr,
  input  logic [WIDTH-1:0]    datain,
  output logic [WIDTH-1:0]    dataout,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);
  logic [PRESC_WIDTH:0]   ctrl;
  logic [WIDTH-1:0]       period, per_act, counter;
  logic [CHANNELS-1:0]    pol, raw;
  logic [WIDTH-1:0]       duty     [CHANNELS];
  logic [WIDTH-1:0]       duty_act [CHANNELS];
  logic [PRESC_WIDTH-1:0] presc_cnt;
  logic                   en, tick, wrap, load;

  assign en   = ctrl[0];
  assign tick = en && presc_cnt == ctrl[PRESC_WIDTH:1];
  assign wrap = tick && counter == per_act;
  assign load = !en || wrap;

  // readback of the software-visible registers, zero when not a read
  always_comb begin
    dataout = '0;
    if (cs && !we) begin
      dataout = addr == 4'd0 ? WIDTH'(ctrl) : addr == 4'd1 ? period : addr == 4'd2 ? WIDTH'(pol) : '0;
      for (int c = 0; c < CHANNELS; c++)
        if (addr == 4'(c + 3)) dataout = duty[c];
    end
  end

  // software-written registers; upper bits of narrow fields are dropped
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      ctrl   <= '0;
      period <= '0;
      pol    <= '0;
      duty   <= '{default: '0};
    end else if (cs && we) begin
      if (addr == 4'd0) ctrl <= datain[PRESC_WIDTH:0];
      if (addr == 4'd1) period <= datain;
      if (addr == 4'd2) pol <= CHANNELS'(datain);
      for (int c = 0; c < CHANNELS; c++)
        if (addr == 4'(c + 3)) duty[c] <= datain;
    end
  end

  // shadows track the written values while idle and latch only at wrap while running
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      per_act  <= '0;
      duty_act <= '{default: '0};
    end else if (load) begin
      per_act  <= period;
      duty_act <= duty;
    end
  end

  // shared prescaler and period counter, plus the registered wrap pulse
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      presc_cnt   <= '0;
      counter     <= '0;
      period_tick <= 1'b0;
    end else begin
      presc_cnt   <= !en || tick ? '0 : presc_cnt + 1'b1;
      counter     <= !en || wrap ? '0 : tick ? counter + 1'b1 : counter;
      period_tick <= wrap;
    end
  end

  // per-channel compare against the active duty
  always_comb begin
    raw = '0;
    for (int c = 0; c < CHANNELS; c++)
      raw[c] = en && counter < duty_act[c];
  end

  // output stage applies polarity and adds one cycle of latency
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) pwm_out <= '0;
    else pwm_out <= raw ^ pol;
  end
endmodule
